alu_wb_stage: RTL
=================

Name: alu_wb_stage

Overview:
- Downstream stage of the 32-bit ALU: captures each ALU result (FINAL, STATUS, opcode) plus a destination register index, and buffers it in a small FIFO.
- Drains the FIFO to the register-file writeback port under a valid/ready handshake.
- Drops results from unassigned opcodes, counting each drop, and keeps sticky status flags for the control unit.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 5, width of destination register index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept; equals !full.
- in_result  input  32  ALU FINAL.
- in_status  input  4  ALU STATUS.
- in_opcode  input  4  opcode that produced the result.
- in_dest  input  AW  destination register index.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  writeback consumes head.
- out_result  output  32  head result.
- out_status  output  4  head status.
- out_dest  output  AW  head destination.
- count  output  $clog2(DEPTH)+1  current occupancy.
- flags_clr  input  1  clear sticky flags.
- sticky_status  output  4  bitwise OR of status of all stored entries since last clear.
- illegal_cnt  output  8  number of dropped results, saturating.

Behaviour:
- Reset (async, rst=1):
  - Pointers, count, sticky_status and illegal_cnt go to 0.
  - out_valid=0 and in_ready=1.
  - out_result, out_status and out_dest read 0, because FIFO storage is also cleared.
  - Reset mid-transfer discards all buffered entries, with no partial output.
- Accept: in_valid & in_ready at an edge.
- Legal opcodes are 4'b0001 to 4'b0111. For a legal opcode, the accepted entry is written at the tail.
- Illegal opcodes (4'b0000 and 4'b1000 to 4'b1111):
  - The handshake still completes and the entry is not written.
  - illegal_cnt increments; it saturates at 255 and does not wrap.
- Pop: out_valid & out_ready at an edge; the head pointer advances.
- Read path:
  - out_* are driven combinationally from the head storage entry, which is itself a register.
  - Latency from accept to out_valid is 1 cycle: accept at edge N gives out_valid=1 after edge N.
- FIFO pointers:
  - Pointers are $clog2(DEPTH)+1 bits wide, with an extra wrap bit.
  - Full when the index bits are equal and the wrap bits differ.
  - Empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH.
- Full:
  - in_ready=0, even if a pop occurs in the same cycle; there is no same-cycle pass-through.
  - Pushes are never lost, because the upstream holds in_valid.
- Empty: out_valid=0; out_ready is ignored.
- Simultaneous legal push and pop while not full and not empty: count is unchanged and both pointers advance.
- Simultaneous push and pop while empty: only the push occurs.
- count is updated +1, -1 or 0 per edge, consistent with the pointers.
- Sticky flags:
  - On a legal accept: sticky_status <= sticky_status | in_status.
  - When flags_clr=1 with no legal accept: sticky_status <= 0.
  - When flags_clr=1 on the same edge as a legal accept: sticky_status <= in_status (the clear happens first, then the new status is ORed in).
  - Illegal results never affect sticky_status.
- in_* are sampled only when in_valid & in_ready; otherwise they are don't-care.

Optional Feature:
- Macro: ALU_WB_OPCNT_EN.
- Defined: adds output port op_cnt [31:0]; it counts completed pops, resets to 0 and wraps modulo 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then push opcode 4'b0001, result 32'h0000_0005, status 4'b0000, dest 3 with out_ready=0 -> next cycle out_valid=1, out_result=5, out_dest=3, count=1; pulsing rst mid-cycle -> out_valid=0 and count=0 immediately.
- Push 4 legal entries (results 1, 2, 3, 4) with out_ready=0 -> count=4 and in_ready=0. A fifth push is held. Raise out_ready -> pops in order 1, 2, 3, 4; the held push is accepted in the cycle after the first pop.
- Push opcodes 4'b0000, 4'b1000 and 4'b1111 -> all three handshakes complete, count stays 0, illegal_cnt=3. Then 300 illegal pushes -> illegal_cnt=255.
- Push statuses 4'b0001 then 4'b0100 -> sticky_status=4'b0101. Then flags_clr together with a legal push of status 4'b1000 -> sticky_status=4'b1000. Then flags_clr alone -> 4'b0000.
- Continuous push and pop with out_ready=1 for 20 entries (results 0 to 19) -> count stays at 1 after the first accept, all 20 results emerge in order, and the pointers wrap past 2*DEPTH without loss.
- With ALU_WB_OPCNT_EN defined: after the 20-entry stream, op_cnt=20; after rst, op_cnt=0.

Source files
------------

// File: rtl/alu_wb_stage.sv
//==============================================================================
// Module   : alu_wb_stage
// Brief    : ALU writeback buffer. FIFO of results drained to the register-file
//            port, illegal-opcode drop counter and sticky status flags.
//            Optional macro ALU_WB_OPCNT_EN adds the op_cnt pop counter.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module alu_wb_stage #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [3:0]               in_status,
  input  logic [3:0]               in_opcode,
  input  logic [AW-1:0]            in_dest,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_status,
  output logic [AW-1:0]            out_dest,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     flags_clr,
  output logic [3:0]               sticky_status,
`ifdef ALU_WB_OPCNT_EN
  output logic [31:0]              op_cnt,
`endif
  output logic [7:0]               illegal_cnt
);

  localparam int c_iw = $clog2(DEPTH);
  localparam int c_pw = c_iw + 1;

  logic [31:0]   r_mem_result [DEPTH];
  logic [3:0]    r_mem_status [DEPTH];
  logic [AW-1:0] r_mem_dest   [DEPTH];

  logic [c_pw-1:0] r_wp;
  logic [c_pw-1:0] r_rp;
  logic [c_pw-1:0] r_count;
  logic [3:0]      r_sticky;
  logic [7:0]      r_illegal;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_legal;
  logic            w_wr;
  logic            w_pop;
  logic [c_iw-1:0] w_widx;
  logic [c_iw-1:0] w_ridx;

  assign w_widx  = r_wp[c_iw-1:0];
  assign w_ridx  = r_rp[c_iw-1:0];
  assign w_full  = (w_widx == w_ridx) && (r_wp[c_iw] != r_rp[c_iw]);
  assign w_empty = (r_wp == r_rp);

  // Legal opcodes are 1..7: nonzero with the top bit clear.
  assign w_legal = (in_opcode != 4'd0) && !in_opcode[3];
  assign w_push  = in_valid && !w_full;
  assign w_wr    = w_push && w_legal;
  assign w_pop   = !w_empty && out_ready;

  assign in_ready      = !w_full;
  assign out_valid     = !w_empty;
  assign out_result    = r_mem_result[w_ridx];
  assign out_status    = r_mem_status[w_ridx];
  assign out_dest      = r_mem_dest[w_ridx];
  assign count         = r_count;
  assign sticky_status = r_sticky;
  assign illegal_cnt   = r_illegal;

  // Storage is cleared on reset so the read port shows zeros while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_result[i] <= '0;
        r_mem_status[i] <= '0;
        r_mem_dest[i]   <= '0;
      end
    end else if (w_wr) begin
      r_mem_result[w_widx] <= in_result;
      r_mem_status[w_widx] <= in_status;
      r_mem_dest[w_widx]   <= in_dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + c_pw'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + c_pw'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + c_pw'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - c_pw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky  <= '0;
      r_illegal <= '0;
    end else begin
      if (w_wr) begin
        r_sticky <= (flags_clr ? 4'd0 : r_sticky) | in_status;
      end else if (flags_clr) begin
        r_sticky <= '0;
      end
      if (w_push && !w_legal && (r_illegal != 8'hFF)) begin
        r_illegal <= r_illegal + 8'd1;
      end
    end
  end

`ifdef ALU_WB_OPCNT_EN
  logic [31:0] r_op_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_cnt <= '0;
    end else if (w_pop) begin
      r_op_cnt <= r_op_cnt + 32'd1;
    end
  end

  assign op_cnt = r_op_cnt;
`endif

endmodule

`default_nettype wire
